// File: rtl/piano_key_ctrl_if.sv
// Key/tone bus between the push-button front end and the tone generator.
//   keys        : raw active-high buttons, index 0 = C4 .. 6 = B4
//   half_period : terminal count for the square-wave toggle counter
//   note_idx    : sounding key index, 7 = none
//   tone_en     : high while a note sounds
//   note_change : one-cycle pulse on every note_idx change
// master = key controller, slave = downstream tone generator / key source.
interface piano_key_ctrl_if #(
  parameter int NUM_KEYS = 7,
  parameter int HP_W     = 19
);
  logic [NUM_KEYS-1:0] keys;
  logic [HP_W-1:0]     half_period;
  logic [2:0]          note_idx;
  logic                tone_en;
  logic                note_change;

  modport master (
    input  keys,
    output half_period, note_idx, tone_en, note_change
  );

  modport slave (
    output keys,
    input  half_period, note_idx, tone_en, note_change
  );
endinterface

// File: rtl/piano_key_ctrl.sv
// Piano key controller: synchronises and debounces one octave of buttons,
// picks the lowest held key and publishes its half-period terminal count.
//   clk   : system clock (50 MHz)
//   rst_n : asynchronous active-low reset
//   bus   : piano_key_ctrl_if master (keys in; half_period, note_idx,
//           tone_en, note_change out)

// Per-key two-flop synchroniser plus stability counter.
//   key : raw async button     db : debounced level
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic db
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta, s;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      s    <= 1'b0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      meta <= key;
      s    <= meta;
      // Any return to the accepted level restarts the count, so the counter
      // can only reach LAST after an unbroken run of differing samples.
      if (s == db) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        db  <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module piano_key_ctrl #(
  parameter int NUM_KEYS        = 7,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HP_W            = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  piano_key_ctrl_if.master    bus
);
  localparam logic [2:0] NONE = 3'd7;

  typedef enum logic {IDLE, PLAY} state_t;

  // round(50e6 / (2 f)) - 1 for C4..B4
  function automatic logic [HP_W-1:0] hp_lut(input logic [2:0] idx);
    case (idx)
      3'd0:    hp_lut = HP_W'(95555);
      3'd1:    hp_lut = HP_W'(85130);
      3'd2:    hp_lut = HP_W'(75842);
      3'd3:    hp_lut = HP_W'(71585);
      3'd4:    hp_lut = HP_W'(63775);
      3'd5:    hp_lut = HP_W'(56817);
      3'd6:    hp_lut = HP_W'(50618);
      default: hp_lut = '0;
    endcase
  endfunction

  logic [NUM_KEYS-1:0] db;
  logic [2:0]          sel;
  logic                any_key;

  state_t              state;
  logic [HP_W-1:0]     half_period;
  logic [2:0]          note_idx;
  logic                tone_en;
  logic                note_change;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (bus.keys[i]),
      .db    (db[i])
    );
  end

  // Lowest held index wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    sel = NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (db[i]) sel = 3'(i);
    end
  end

  assign any_key = |db;

  // All debounced keys are evaluated together each cycle, so simultaneous
  // changes collapse into a single load and a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      half_period <= '0;
      note_idx    <= NONE;
      tone_en     <= 1'b0;
      note_change <= 1'b0;
    end else begin
      note_change <= 1'b0;
      case (state)
        IDLE: begin
          if (any_key) begin
            state       <= PLAY;
            note_idx    <= sel;
            half_period <= hp_lut(sel);
            tone_en     <= 1'b1;
            note_change <= 1'b1;
          end
        end
        PLAY: begin
          if (!any_key) begin
            // half_period is left alone so the generator idles on the last tone
            state       <= IDLE;
            note_idx    <= NONE;
            tone_en     <= 1'b0;
            note_change <= 1'b1;
          end else if (sel != note_idx) begin
            note_idx    <= sel;
            half_period <= hp_lut(sel);
            note_change <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.half_period = half_period;
  assign bus.note_idx    = note_idx;
  assign bus.tone_en     = tone_en;
  assign bus.note_change = note_change;
endmodule

// File: tb/tb_piano_key_ctrl.sv
module tb_piano_key_ctrl;
  localparam int NK = 7;
  localparam int DC = 8;
  localparam int HW = 19;
  localparam int LAT = 2 + DC + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  piano_key_ctrl_if #(.NUM_KEYS(NK), .HP_W(HW)) bus ();

  piano_key_ctrl #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DC), .HP_W(HW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int hp_tab [7] = '{95555, 85130, 75842, 71585, 63775, 56817, 50618};

  int errors = 0;
  int checks = 0;
  int pulses, first_pulse, tone_low, back2back;
  logic prev_nc = 1'b0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Step n cycles, sampling after each rising edge (on the falling edge).
  // Sample k is the state after the k-th rising edge from the call.
  task automatic step(input int n);
    pulses = 0; first_pulse = -1; tone_low = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (bus.note_change) begin
        pulses++;
        if (first_pulse < 0) first_pulse = k;
        if (prev_nc) back2back++;
      end
      if (!bus.tone_en) tone_low++;
      prev_nc = bus.note_change;
    end
  endtask

  task automatic chk_out(input string tag, input int en, input int idx, input int hp);
    chk({tag, ".tone_en"}, int'(bus.tone_en), en);
    chk({tag, ".note_idx"}, int'(bus.note_idx), idx);
    chk({tag, ".half_period"}, int'(bus.half_period), hp);
  endtask

  initial begin
    back2back = 0;
    bus.keys = '0;
    repeat (3) @(negedge clk);
    chk_out("reset", 0, 7, 0);
    chk("reset.note_change", int'(bus.note_change), 0);
    rst_n = 1'b1;
    step(3);

    // 1: clean press / release of E4
    bus.keys = 7'b000_0100;
    step(LAT - 1);
    chk("t1.press.early", int'(bus.tone_en), 0);
    step(9);
    chk("t1.press.lat", first_pulse, 1);
    chk("t1.press.pulses", pulses, 1);
    chk_out("t1.press", 1, 2, 75842);
    bus.keys = '0;
    step(20);
    chk("t1.rel.lat", first_pulse, LAT);
    chk("t1.rel.pulses", pulses, 1);
    chk_out("t1.rel", 0, 7, 75842);

    // 2: bounce on C4 never stays high long enough
    bus.keys = 7'b000_0001; step(5);
    chk("t2.a.pulses", pulses, 0);
    bus.keys = '0;          step(3);
    bus.keys = 7'b000_0001; step(5);
    chk("t2.b.pulses", pulses, 0);
    bus.keys = '0;          step(20);
    chk("t2.c.pulses", pulses, 0);
    chk_out("t2", 0, 7, 75842);

    // 3: G4 held, D4 added then released
    bus.keys = 7'b001_0000; step(20);
    chk_out("t3.g4", 1, 4, 63775);
    bus.keys = 7'b001_0010; step(20);
    chk("t3.add.pulses", pulses, 1);
    chk("t3.add.lat", first_pulse, LAT);
    chk_out("t3.d4", 1, 1, 85130);
    bus.keys = 7'b001_0000; step(20);
    chk("t3.rel.pulses", pulses, 1);
    chk("t3.rel.tone_low", tone_low, 0);
    chk_out("t3.back", 1, 4, 63775);
    bus.keys = '0; step(20);
    chk_out("t3.off", 0, 7, 63775);

    // 4: C4 and B4 on the same cycle
    bus.keys = 7'b100_0001; step(20);
    chk("t4.pulses", pulses, 1);
    chk_out("t4", 1, 0, 95555);
    bus.keys = 7'b100_0000; step(20);
    chk_out("t4.b4", 1, 6, 50618);

    // 5: async reset pulse while B4 plays
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_out("t5.rst", 0, 7, 0);
    chk("t5.rst.note_change", int'(bus.note_change), 0);
    rst_n = 1'b1;
    step(20);
    chk("t5.lat", first_pulse, LAT);
    chk("t5.pulses", pulses, 1);
    chk_out("t5", 1, 6, 50618);
    bus.keys = '0; step(20);

    // 6: sweep every key
    for (int i = 0; i < NK; i++) begin
      bus.keys = 7'(1 << i); step(20);
      chk($sformatf("t6.k%0d.pulses", i), pulses, 1);
      chk_out($sformatf("t6.k%0d", i), 1, i, hp_tab[i]);
      bus.keys = '0; step(20);
      chk($sformatf("t6.k%0d.off", i), int'(bus.note_idx), 7);
    end
    chk("t6.back2back", back2back, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
